// File: rtl/tx_block.sv
// 8N1 serial transmitter with a one-byte holding buffer in front of the shift register.
// A byte written while the buffer is full is dropped and latches a sticky overrun flag.
module tx_block #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  input  logic       error_clr,
  output logic       serial_out,
  output logic       buffer_empty,
  output logic       tx_busy,
  output logic       overrun_error,
  output logic [2:0] state
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       buf_q, buf_d;
  logic             full_q, full_d;
  logic             line_q, line_d;
  logic             ovr_q, ovr_d;
  logic             bit_end;
  logic             load_frame;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    full_d     = full_q;
    line_d     = line_q;
    ovr_d      = ovr_q;
    load_frame = 1'b0;
    bit_end    = (baud_q == BAUD_LAST);

    baud_d = bit_end ? '0 : baud_q + 1'b1;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        line_d = 1'b1;
        if (full_q) load_frame = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
          line_d  = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            line_d  = 1'b1;
          end else begin
            // The next data bit is already sitting one position up in the shifter.
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            line_d  = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (full_q) begin
            load_frame = 1'b1;
          end else begin
            state_d = IDLE;
            line_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = 3'd0;
        line_d  = 1'b1;
      end
    endcase

    if (load_frame) begin
      state_d = START;
      baud_d  = '0;
      bit_d   = 3'd0;
      shift_d = buf_q;
      full_d  = 1'b0;
      line_d  = 1'b0;
    end

    // A clear and a fresh overrun on the same edge leave the flag set.
    if (error_clr) ovr_d = 1'b0;
    if (tx_load) begin
      if (!full_q) begin
        buf_d  = tx_data;
        full_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      buf_q   <= 8'h00;
      full_q  <= 1'b0;
      line_q  <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      line_q  <= line_d;
      ovr_q   <= ovr_d;
    end
  end

  assign serial_out    = line_q;
  assign buffer_empty  = ~full_q;
  assign tx_busy       = (state_q != IDLE);
  assign overrun_error = ovr_q;
  assign state         = state_q;

endmodule

// File: doc/tx_block.md
TX_BLOCK -- requirements
Module: tx_block

Parameters
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 10, meaning the number of clk cycles per serial bit; legal values are 2 or more.

Interface
REQ-002 SHALL provide clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL provide rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL provide tx_data  input  8  byte to transmit; sampled only when tx_load is accepted.
REQ-005 SHALL provide tx_load  input  1  single-cycle write strobe into the holding buffer.
REQ-006 SHALL provide error_clr  input  1  clears overrun_error.
REQ-007 SHALL provide serial_out  output  1  serial line; idle high; driven from a register.
REQ-008 SHALL provide buffer_empty  output  1  holding buffer can accept a byte.
REQ-009 SHALL provide tx_busy  output  1  a frame is on the line.
REQ-010 SHALL provide overrun_error  output  1  sticky flag: a load arrived while the buffer was full.
REQ-011 SHALL provide state  output  3  FSM state, for debug.

Function
REQ-012 SHALL use frame format 8N1: start bit 0, data bits 0..7 LSB first, stop bit 1, for 10 bits per frame.
REQ-013 SHALL hold every bit on serial_out for exactly CLKS_PER_BIT cycles; a frame lasts 10*CLKS_PER_BIT cycles.
REQ-014 SHALL implement FSM states IDLE=3'd0, START=3'd1, DATA=3'd2, STOP=3'd3; values 3'd4 to 3'd7 SHALL recover to IDLE.
REQ-015 SHALL accept tx_load only when buffer_empty=1 at that edge: tx_data is captured and buffer_empty becomes 0 after the edge.
REQ-016 SHALL, on tx_load while buffer_empty=0, discard tx_data, keep the buffer unchanged and set overrun_error=1 after the edge.
REQ-017 SHALL clear overrun_error on an error_clr edge; when error_clr and a new overrun occur on the same edge, the set wins.
REQ-018 SHALL, in IDLE with buffer_empty=0, move the buffer into the shift register on the next edge; after that edge state=START, serial_out=0, buffer_empty=1 and tx_busy=1.
REQ-019 SHALL give a latency of 2 edges: tx_load sampled at edge k in IDLE with an empty buffer makes serial_out fall after edge k+1.
REQ-020 SHALL stay in START for CLKS_PER_BIT cycles, then enter DATA.
REQ-021 SHALL stay in DATA for 8*CLKS_PER_BIT cycles, shifting right once per bit period; a 3-bit bit counter goes 0..7 with no wrap beyond 7.
REQ-022 SHALL stay in STOP for CLKS_PER_BIT cycles with serial_out=1.
REQ-023 SHALL, at the end of STOP with buffer_empty=0, transfer the buffer and go straight to START with no idle cycle.
REQ-024 SHALL, at the end of STOP with buffer_empty=1, go to IDLE with serial_out=1 and tx_busy=0.
REQ-025 SHALL use a baud counter of width ceil(log2(CLKS_PER_BIT)) that counts 0..CLKS_PER_BIT-1, clears on every bit boundary, and clears on every state entry.
REQ-026 SHALL let a byte loaded during START, DATA or STOP wait in the buffer without affecting the current frame.

Reset
REQ-027 SHALL, while rst=1 and immediately on assertion, force serial_out=1, buffer_empty=1, tx_busy=0, overrun_error=0 and state=IDLE, and clear the counters and shift register.
REQ-028 SHALL abort a frame in progress on reset with no partial stop bit; the line returns high asynchronously.
REQ-029 SHALL ignore tx_load while rst=1.

Verification
REQ-030 Single byte, CLKS_PER_BIT=10: load 8'hD5 -> serial_out is 0,1,0,1,0,1,0,1,1,1 with each bit 10 cycles; tx_busy high for 100 cycles; serial_out falls after edge k+1.
REQ-031 Back-to-back: load 8'hA5, then load 8'h3C when buffer_empty rises -> 200 continuous cycles, the stop bit of the first frame is followed immediately by the start bit of the second, and there is no idle cycle.
REQ-032 Overrun: load 8'h11, 8'h22, then 8'h33 while the buffer is full -> overrun_error=1 after the third edge; only 8'h11 and 8'h22 are transmitted; error_clr drives overrun_error to 0.
REQ-033 Reset mid-frame: assert rst during data bit 4 of 8'hF0 -> serial_out=1, state=0 and buffer_empty=1 without waiting for a clock; a subsequent load of 8'h5A transmits correctly.
REQ-034 Data extremes and idle: 8'h00 gives 9 low bit periods then a high stop bit; 8'hFF gives 1 low bit period then 9 high; with no load for 50 cycles serial_out stays 1 and state stays 0.
REQ-035 Boundary: CLKS_PER_BIT=2 with 8'h96 -> frame lasts exactly 20 cycles and the bit pattern is correct.
